t03_screen_sequencer: RTL and testbench

Screen and round sequencer that drives the 3-bit `game_state` bus consumed by the team-03 alphabet/text decoder. It steps the display through title, a three-step countdown, the fight, and the winner screens, using frame ticks from the VGA timing block. It also gates the game logic through `fight_en` and tells the text renderer when to redraw. It sits between the input synchronizers, the health/combat logic and the text path.

---
 rtl/t03_pkg.sv | 24 ++
 rtl/t03_frame_timer.sv | 27 ++
 rtl/t03_screen_sequencer.sv | 90 +++++++++
 tb/tb_t03_screen_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/t03_pkg.sv
// Shared definitions for the team-03 screen path: screen encoding seen by the
// text decoder and the default frame counts used by the sequencer.
package t03_pkg;

  typedef enum logic [2:0] {
    TITLE = 3'd0,
    CNT3  = 3'd1,
    CNT2  = 3'd2,
    CNT1  = 3'd3,
    FIGHT = 3'd4,
    WIN1  = 3'd5,
    WIN2  = 3'd6
  } game_state_t;

  localparam int DEFAULT_COUNT_FRAMES = 60;
  localparam int DEFAULT_WIN_FRAMES   = 180;
  localparam int DEFAULT_CNT_W        = 8;

  // Screens whose length is measured in frames; TITLE and FIGHT wait on events.
  function automatic logic is_timed_screen(input game_state_t s);
    return (s == CNT3) || (s == CNT2) || (s == CNT1) || (s == WIN1) || (s == WIN2);
  endfunction

endpackage

// File: rtl/t03_frame_timer.sv
// Frame counter for timed screens: counts ticks since the last clear and flags
// the tick that completes `limit` frames.
module t03_frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] fcnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fcnt <= '0;
    end else if (tick) begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // A tick during the clearing cycle belongs to the screen being entered and is not counted.
  assign done = tick & ~clr & (fcnt == (limit - 1'b1));

endmodule

// File: rtl/t03_screen_sequencer.sv
// Screen and round sequencer: title, three-step countdown, fight, winner screens.
// Drives the decoder's game_state bus and gates/redraws the rest of the game.
module t03_screen_sequencer
  import t03_pkg::*;
#(
  parameter int COUNT_FRAMES = DEFAULT_COUNT_FRAMES,
  parameter int WIN_FRAMES   = DEFAULT_WIN_FRAMES,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       p1_ko,
  input  logic       p2_ko,
  output logic [2:0] game_state,
  output logic       fight_en,
  output logic       redraw,
  output logic       round_reset
);

  localparam logic [CNT_W-1:0] COUNT_LIMIT = CNT_W'(COUNT_FRAMES);
  localparam logic [CNT_W-1:0] WIN_LIMIT   = CNT_W'(WIN_FRAMES);

  game_state_t      state;
  game_state_t      next_state;
  logic             start_q;
  logic             start_rise;
  logic             round_reset_d;
  logic             timer_tick;
  logic             timer_done;
  logic [CNT_W-1:0] timer_limit;

  assign start_rise = start_btn & ~start_q;
  assign game_state = state;

  // start_q resets high so a button held through reset cannot start a game.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TITLE;
      start_q     <= 1'b1;
      fight_en    <= 1'b0;
      redraw      <= 1'b1;
      round_reset <= 1'b0;
    end else begin
      state       <= next_state;
      start_q     <= start_btn;
      fight_en    <= (next_state == FIGHT);
      redraw      <= (next_state != state);
      round_reset <= round_reset_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      TITLE: if (start_rise) next_state = CNT3;
      CNT3:  if (timer_done) next_state = CNT2;
      CNT2:  if (timer_done) next_state = CNT1;
      CNT1:  if (timer_done) next_state = FIGHT;
      FIGHT: begin
        if (p1_ko && p2_ko)      next_state = CNT3;
        else if (p1_ko)          next_state = WIN2;
        else if (p2_ko)          next_state = WIN1;
      end
      WIN1, WIN2: if (timer_done) next_state = TITLE;
      default: next_state = TITLE;
    endcase
  end

  // Both a fresh start and a double-KO rematch restore health and positions.
  always_comb begin
    round_reset_d = ((state == TITLE) && start_rise) || ((state == FIGHT) && p1_ko && p2_ko);
    timer_tick    = frame_tick & is_timed_screen(state);
    timer_limit   = ((state == WIN1) || (state == WIN2)) ? WIN_LIMIT : COUNT_LIMIT;
  end

  // redraw marks the first cycle of every screen, which is also when the timer restarts.
  t03_frame_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (redraw),
    .tick  (timer_tick),
    .limit (timer_limit),
    .done  (timer_done)
  );

endmodule

// File: tb/tb_t03_screen_sequencer.sv
// Directed bench for the screen sequencer with a frame-counting reference model
// compared against the DUT outputs every cycle.
module tb_t03_screen_sequencer;

  localparam int COUNT_FRAMES = 3;
  localparam int WIN_FRAMES   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b1;
  logic       frame_tick = 1'b0;
  logic       p1_ko = 1'b0;
  logic       p2_ko = 1'b0;
  logic [2:0] game_state;
  logic       fight_en;
  logic       redraw;
  logic       round_reset;

  int tests_run = 0;
  int tests_failed = 0;

  t03_screen_sequencer #(
    .COUNT_FRAMES (COUNT_FRAMES),
    .WIN_FRAMES   (WIN_FRAMES),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .frame_tick  (frame_tick),
    .p1_ko       (p1_ko),
    .p2_ko       (p2_ko),
    .game_state  (game_state),
    .fight_en    (fight_en),
    .redraw      (redraw),
    .round_reset (round_reset)
  );

  always #5 clk = ~clk;

  // Reference model: screen number plus frames seen since the screen began.
  int m_screen = 0;
  int m_frames = 0;
  bit m_first = 1'b1;
  bit m_btn_prev = 1'b1;
  bit m_round_reset = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int nxt;
    int frames;
    bit rr;
    if (rst) begin
      m_screen      <= 0;
      m_frames      <= 0;
      m_first       <= 1'b1;
      m_btn_prev    <= 1'b1;
      m_round_reset <= 1'b0;
      m_valid       <= 1'b1;
    end else begin
      nxt    = m_screen;
      frames = m_frames;
      rr     = 1'b0;
      if (m_screen == 0) begin
        if (start_btn && !m_btn_prev) begin
          nxt = 1;
          rr  = 1'b1;
        end
      end else if (m_screen == 4) begin
        if (p1_ko && p2_ko) begin
          nxt = 1;
          rr  = 1'b1;
        end else if (p1_ko) nxt = 6;
        else if (p2_ko) nxt = 5;
      end else if (frame_tick && !m_first) begin
        frames = frames + 1;
        if (m_screen <= 3 && frames == COUNT_FRAMES) nxt = m_screen + 1;
        if (m_screen >= 5 && frames == WIN_FRAMES) nxt = 0;
      end
      m_btn_prev    <= start_btn;
      m_round_reset <= rr;
      m_first       <= (nxt != m_screen);
      m_frames      <= (nxt != m_screen) ? 0 : frames;
      m_screen      <= nxt;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model game_state", int'(game_state), m_screen);
      checkOutput("model fight_en", int'(fight_en), int'(m_screen == 4));
      checkOutput("model redraw", int'(redraw), int'(m_first));
      checkOutput("model round_reset", int'(round_reset), int'(m_round_reset));
    end
  end

  // Drive one cycle of inputs, then return 1 ns after the clock edge that samples them.
  task automatic applyStimulus(input logic r, input logic b, input logic t, input logic k1, input logic k2);
    rst        = r;
    start_btn  = b;
    frame_tick = t;
    p1_ko      = k1;
    p2_ko      = k2;
    @(posedge clk);
    #1;
  endtask

  task automatic runTicks(input int n, input logic b, input logic k1, input logic k2);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, b, 1'b0, k1, k2);
      applyStimulus(1'b0, b, 1'b1, k1, k2);
    end
  endtask

  task automatic startGame();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start state", int'(game_state), 1);
    checkOutput("start round_reset", int'(round_reset), 1);
    checkOutput("start redraw", int'(redraw), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with the button held high.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset state", int'(game_state), 0);
    checkOutput("reset redraw", int'(redraw), 1);
    checkOutput("reset fight_en", int'(fight_en), 0);
    checkOutput("reset round_reset", int'(round_reset), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("held button no start", int'(game_state), 0);
    checkOutput("redraw one cycle", int'(redraw), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("held button still title", int'(game_state), 0);

    // Start, with a tick in the CNT3 entry cycle that must not count.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("press state", int'(game_state), 1);
    checkOutput("press round_reset", int'(round_reset), 1);
    checkOutput("press redraw", int'(redraw), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("entry tick ignored", int'(game_state), 1);
    runTicks(2, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt3 after 2 ticks", int'(game_state), 1);
    runTicks(1, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt3 to cnt2", int'(game_state), 2);

    // p1_ko during CNT2 is ignored.
    runTicks(2, 1'b0, 1'b1, 1'b0);
    checkOutput("ko ignored in cnt2", int'(game_state), 2);
    runTicks(1, 1'b0, 1'b1, 1'b0);
    checkOutput("cnt2 to cnt1", int'(game_state), 3);
    runTicks(3, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt1 to fight", int'(game_state), 4);
    checkOutput("fight_en in fight", int'(fight_en), 1);

    // Button pulse in FIGHT, then P2 KO coinciding with a tick.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("start ignored in fight", int'(game_state), 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("p2 ko to win1", int'(game_state), 5);
    checkOutput("win1 fight_en", int'(fight_en), 0);
    checkOutput("win1 redraw", int'(redraw), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("start ignored in win1", int'(game_state), 5);
    runTicks(3, 1'b0, 1'b0, 1'b0);
    checkOutput("win1 after 3 ticks", int'(game_state), 5);
    runTicks(1, 1'b0, 1'b0, 1'b0);
    checkOutput("win1 to title", int'(game_state), 0);
    checkOutput("title redraw", int'(redraw), 1);

    // Double KO rematch.
    startGame();
    runTicks(9, 1'b0, 1'b0, 1'b0);
    checkOutput("second fight", int'(game_state), 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("double ko state", int'(game_state), 1);
    checkOutput("double ko round_reset", int'(round_reset), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("round_reset one cycle", int'(round_reset), 0);

    // Mid-round reset in CNT1 with two frames counted.
    runTicks(6, 1'b0, 1'b0, 1'b0);
    checkOutput("rematch cnt1", int'(game_state), 3);
    runTicks(2, 1'b0, 1'b0, 1'b0);
    checkOutput("fcnt before reset", int'(dut.u_timer.fcnt), 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid reset state", int'(game_state), 0);
    checkOutput("mid reset fcnt", int'(dut.u_timer.fcnt), 0);
    checkOutput("mid reset redraw", int'(redraw), 1);
    checkOutput("mid reset round_reset", int'(round_reset), 0);

    // P1 KO path to WIN2 and back.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    startGame();
    runTicks(9, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("p1 ko to win2", int'(game_state), 6);
    runTicks(4, 1'b0, 1'b1, 1'b0);
    checkOutput("win2 to title", int'(game_state), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
